mem_arbiter: RTL

Sequencer for the shared system memory bus (memaddr/memwrite/writedata) between the processor and the DMA controller. It replaces the direct proc_en mux with a registered owner state machine. The state machine inserts one dead cycle at each ownership change, limits DMA burst length, optionally confines DMA to blanking, and guarantees the processor a minimum run window between bursts. It sits between the processor/DMA blocks and the memory controller, GPU and rotary-encoder write ports.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared memory bus sequencer between the processor and the DMA controller.
// A registered owner FSM inserts a dead cycle at every handoff and paces DMA bursts.
module mem_arbiter #(
  parameter int MAX_BURST   = 16,
  parameter int MIN_PROC    = 4,
  parameter int VBLANK_ONLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] proc_memaddr,
  input  logic        proc_memwrite,
  input  logic [15:0] proc_writedata,
  output logic        proc_en,
  input  logic        dma_req,
  input  logic        dma_last,
  input  logic [15:0] dma_memaddr,
  input  logic        dma_memwrite,
  input  logic [15:0] dma_writedata,
  output logic        dma_gnt,
  input  logic        vbright,
  output logic [15:0] memaddr,
  output logic        memwrite,
  output logic [15:0] writedata,
  output logic [7:0]  burst_cnt
);

  typedef enum logic [1:0] {
    PROC    = 2'd0,
    TO_DMA  = 2'd1,
    DMA     = 2'd2,
    TO_PROC = 2'd3
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [7:0] MIN_PROC_C  = 8'(MIN_PROC);
  localparam logic       VBLANK_C    = 1'(VBLANK_ONLY);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] proc_cnt_r;
  logic [7:0] burst_cnt_r;
  logic       proc_en_r;
  logic       dma_gnt_r;
  logic       blank_ok_s;
  logic       eligible_s;
  logic       dma_end_s;
  logic [7:0] burst_inc_s;

  assign proc_en   = proc_en_r;
  assign dma_gnt   = dma_gnt_r;
  assign burst_cnt = burst_cnt_r;

  // Grant and release conditions; a write in the terminating cycle still completes.
  always_comb begin
    blank_ok_s  = ~VBLANK_C | ~vbright;
    eligible_s  = dma_req & (proc_cnt_r >= MIN_PROC_C) & blank_ok_s;
    burst_inc_s = burst_cnt_r + 8'd1;
    dma_end_s   = (dma_memwrite & (burst_inc_s == MAX_BURST_C))
                | (dma_memwrite & dma_last)
                | ~dma_req
                | ~blank_ok_s;
  end

  // Next-state decode; dead cycles always advance unconditionally.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      PROC: begin
        if (eligible_s) begin
          next_state_s = TO_DMA;
        end else begin
          next_state_s = PROC;
        end
      end
      TO_DMA: next_state_s = DMA;
      DMA: begin
        if (dma_end_s) begin
          next_state_s = TO_PROC;
        end else begin
          next_state_s = DMA;
        end
      end
      TO_PROC: next_state_s = PROC;
      default: next_state_s = PROC;
    endcase
  end

  // Owner state, registered enables and the run/burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= PROC;
      proc_en_r   <= 1'b1;
      dma_gnt_r   <= 1'b0;
      burst_cnt_r <= 8'd0;
      proc_cnt_r  <= MIN_PROC_C;
    end else begin
      state_r   <= next_state_s;
      proc_en_r <= (next_state_s == PROC);
      dma_gnt_r <= (next_state_s == DMA);
      case (state_r)
        PROC: begin
          if (proc_cnt_r != 8'hFF) begin
            proc_cnt_r <= proc_cnt_r + 8'd1;
          end
        end
        TO_DMA: burst_cnt_r <= 8'd0;
        DMA: begin
          if (dma_memwrite) begin
            burst_cnt_r <= burst_inc_s;
          end
        end
        TO_PROC: proc_cnt_r <= 8'd0;
        default: begin
          proc_cnt_r  <= proc_cnt_r;
          burst_cnt_r <= burst_cnt_r;
        end
      endcase
    end
  end

  // Bus mux; writes are suppressed in both dead cycles.
  always_comb begin
    memaddr   = proc_memaddr;
    writedata = proc_writedata;
    memwrite  = 1'b0;
    case (state_r)
      PROC: memwrite = proc_memwrite;
      DMA: begin
        memaddr   = dma_memaddr;
        writedata = dma_writedata;
        memwrite  = dma_memwrite;
      end
      default: memwrite = 1'b0;
    endcase
  end

endmodule
